pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register replacing the per-stage hand-written registers (if_id, id_ex, ex_mem, ...).
//  Carries one packed stage payload of DATA_W bits plus a valid bit. Two modes:
//  - MODE_CTRL: central-ctrl stall vector with bubble insertion.
//  - MODE_HS: valid/ready two-entry skid buffer, full throughput.
//  Adds a synchronous flush (branch/jump squash) in both modes.
// PARAMETERS
//  DATA_W    64  payload width (packed pc/aluop/funct3/funct7/reg1/reg2/imm/wreg/wd, etc.)
//  NOP_DATA  0   payload driven whenever the stage holds no valid entry (NOP encoding)
//  MODE      0   0 = MODE_CTRL (ctrl stall bits), 1 = MODE_HS (valid/ready skid)
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       synchronous reset, active-high
//  flush      in   1       discard all held entries this edge
//  stall_cur  in   1       MODE_CTRL: this stage's stall bit (1 = Stop); ignored in MODE_HS
//  stall_nxt  in   1       MODE_CTRL: next stage's stall bit; ignored in MODE_HS
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage accepts in_data this cycle
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       out_data holds a valid entry
//  out_ready  in   1       MODE_HS: downstream consumes; ignored in MODE_CTRL
//  out_data   out  DATA_W  payload to next stage; NOP_DATA when out_valid=0
//  occ        out  2       entries held (0..2; max 1 in MODE_CTRL)
// BEHAVIOUR
//  Reset (rst=1 at posedge): all valid bits 0, all payload regs NOP_DATA, occ=0.
//    After reset, in_ready=1 (MODE_HS), and in_ready=~stall_cur (MODE_CTRL).
//  Priority at every edge: rst > flush > mode logic. Flush clears exactly as reset does.
//    Any input presented in the flush cycle is dropped, even if in_ready was 1.
//  MODE_CTRL (single entry):
//  - in_ready = ~stall_cur (combinational).
//  - stall_cur=1, stall_nxt=0: load bubble (valid 0, data NOP_DATA).
//  - stall_cur=1, stall_nxt=1: hold all state.
//  - stall_cur=0: valid <= in_valid; data <= in_valid ? in_data : NOP_DATA.
//  - Latency 1 cycle.
//  MODE_HS (states EMPTY/ONE/FULL; main reg drives out_data; skid reg is the overflow):
//  - in_ready is registered, equal to (state != FULL). push = in_valid & in_ready; pop = out_valid & out_ready.
//  - EMPTY: push -> ONE (main <= in_data).
//  - ONE:
//      - push & pop -> ONE (main <= in_data).
//      - push only -> FULL (skid <= in_data).
//      - pop only -> EMPTY.
//  - FULL: no push possible. pop -> ONE (main <= skid, skid <= NOP_DATA).
//  - pop while out_valid=0 has no effect. out_ready may toggle freely; out_data is stable while out_valid & ~out_ready.
//  - FIFO order is always preserved. Latency in->out is 1 cycle. Sustained push+pop gives 1 entry/cycle.
//  - Unused regs are held at NOP_DATA, so out_data is never stale garbage.
//  occ: EMPTY=0, ONE=1, FULL=2 (MODE_CTRL: {1'b0,valid}).
//  No X propagation: in_data is sampled only on push/load.
// STRUCTURE
//  defs.v (shared) gains: MODE_CTRL/MODE_HS constants, 2-bit state encodings (EMPTY=00, ONE=01, FULL=10), Stop/Continue as used by ctrl.
//  One sub-module: pipe_skid_buf (two-entry storage + state machine), instantiated by generate when MODE==MODE_HS.
//  MODE_CTRL logic is inline.
// TESTING
//  1 rst=1 for 2 cycles mid-transfer (FULL) -> out_valid=0, out_data=NOP_DATA, occ=0, in_ready=1 next cycle.
//  2 MODE_CTRL, in_data=0xA5A5, stall_cur=0 -> out_data=0xA5A5 after 1 edge;
//    then stall_cur=1, stall_nxt=1 for 3 edges -> held 0xA5A5;
//    then stall_cur=1, stall_nxt=0 -> bubble: out_valid=0, out_data=NOP_DATA.
//  3 MODE_HS, push 1,2,3 on consecutive cycles with out_ready=0 -> occ 1,2,2; in_ready=0 after 2nd push; value 3 not accepted; out_data=1.
//  4 from test 3's FULL state, out_ready=1 for 2 cycles -> out_data 1 then 2; occ 1 then 0; in_ready=1 one cycle after first pop.
//  5 MODE_HS, continuous push 0..15 with out_ready=1 -> outputs 0..15, one per cycle, in order; occ stays 1.
//  6 flush asserted in FULL state with simultaneous push of 0x77 -> next cycle occ=0, out_valid=0; 0x77 never appears on out_data.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
package pipe_stage_reg_pkg;

  // Operating modes selected by the MODE parameter.
  localparam int unsigned ModeCtrl = 0;
  localparam int unsigned ModeHs   = 1;

  // Stall-bit encoding used by the central pipeline controller.
  localparam logic Stop     = 1'b1;
  localparam logic Continue = 1'b0;

  // Skid buffer occupancy states; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } skid_state_e;

  // Number of entries held in a given skid state.
  function automatic logic [1:0] occ_of(skid_state_e st);
    logic [1:0] n;
    n = 2'd0;
    unique case (st)
      StEmpty: n = 2'd0;
      StOne:   n = 2'd1;
      StFull:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer: main register drives the output,
// skid register absorbs the one entry accepted while downstream stalls.
module pipe_skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned         DATA_W   = 64,
  parameter logic [DATA_W-1:0]   NOP_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              push, pop;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready_o  = (state_q != StFull);
  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = main_q;
  assign occ_o       = occ_of(state_q);

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // Next-state: in_data is captured only on push; vacated regs return to NOP.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          state_d = StOne;
          main_d  = in_data_i;
        end
      end
      StOne: begin
        if (push && pop) begin
          main_d = in_data_i;
        end else if (push) begin
          state_d = StFull;
          skid_d  = in_data_i;
        end else if (pop) begin
          state_d = StEmpty;
          main_d  = NOP_DATA;
        end
      end
      StFull: begin
        if (pop) begin
          state_d = StOne;
          main_d  = skid_q;
          skid_d  = NOP_DATA;
        end
      end
      default: begin
        state_d = StEmpty;
        main_d  = NOP_DATA;
        skid_d  = NOP_DATA;
      end
    endcase
  end

  // State registers; reset and flush both empty the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= StEmpty;
      main_q  <= NOP_DATA;
      skid_q  <= NOP_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: either controller-stalled single entry
// with bubble insertion, or a full-throughput valid/ready skid buffer.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W   = 64,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int unsigned       MODE     = ModeCtrl
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_cur,
  input  logic              stall_nxt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  if (MODE == ModeHs) begin : g_hs
    pipe_skid_buf #(
      .DATA_W   (DATA_W),
      .NOP_DATA (NOP_DATA)
    ) u_skid (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .occ_o       (occ)
    );

    // Stall bits have no meaning in handshake mode.
    logic unused_stall;
    assign unused_stall = stall_cur ^ stall_nxt;
  end else begin : g_ctrl
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready  = (stall_cur == Continue);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign occ       = {1'b0, valid_q};

    // Single entry: load, insert a bubble, or hold, as the stall bits dictate.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        valid_q <= 1'b0;
        data_q  <= NOP_DATA;
      end else if (stall_cur == Stop) begin
        if (stall_nxt == Continue) begin
          valid_q <= 1'b0;
          data_q  <= NOP_DATA;
        end
      end else begin
        valid_q <= in_valid;
        data_q  <= in_valid ? in_data : NOP_DATA;
      end
    end

    // Downstream readiness is implied by the controller in this mode.
    logic unused_ready;
    assign unused_ready = out_ready;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one controller-mode and one handshake-mode
// instance; the handshake side is tracked by a queue scoreboard.
module tb_pipe_stage_reg;

  localparam int unsigned DW  = 16;
  localparam logic [DW-1:0] NOP = 16'hC0DE;

  logic clk, rst;

  logic          c_flush, c_stall_cur, c_stall_nxt, c_in_valid, c_in_ready;
  logic [DW-1:0] c_in_data, c_out_data;
  logic          c_out_valid, c_out_ready;
  logic [1:0]    c_occ;

  logic          h_flush, h_stall_cur, h_stall_nxt, h_in_valid, h_in_ready;
  logic [DW-1:0] h_in_data, h_out_data;
  logic          h_out_valid, h_out_ready;
  logic [1:0]    h_occ;

  int n_total = 0;
  int n_bad   = 0;
  bit mon_en  = 0;
  logic [DW-1:0] sb_q[$];

  pipe_stage_reg #(.DATA_W(DW), .NOP_DATA(NOP), .MODE(0)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (c_flush),
    .stall_cur (c_stall_cur),
    .stall_nxt (c_stall_nxt),
    .in_valid  (c_in_valid),
    .in_ready  (c_in_ready),
    .in_data   (c_in_data),
    .out_valid (c_out_valid),
    .out_ready (c_out_ready),
    .out_data  (c_out_data),
    .occ       (c_occ)
  );

  pipe_stage_reg #(.DATA_W(DW), .NOP_DATA(NOP), .MODE(1)) u_hs (
    .clk       (clk),
    .rst       (rst),
    .flush     (h_flush),
    .stall_cur (h_stall_cur),
    .stall_nxt (h_stall_nxt),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .in_data   (h_in_data),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .out_data  (h_out_data),
    .occ       (h_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare against the model before the edge, then apply the edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int sz;
      sz = sb_q.size();
      check("hs_vld", 32'(h_out_valid), 32'(sz != 0));
      check("hs_occ", 32'(h_occ), 32'(sz));
      check("hs_rdy", 32'(h_in_ready), 32'(sz < 2));
      if (sz == 0) check("hs_nop", 32'(h_out_data), 32'(NOP));
      else         check("hs_data", 32'(h_out_data), 32'(sb_q[0]));
      if (rst || h_flush) begin
        sb_q.delete();
      end else begin
        if (h_out_ready && sz > 0) void'(sb_q.pop_front());
        if (h_in_valid && sz < 2) sb_q.push_back(h_in_data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    c_flush = 0; c_stall_cur = 0; c_stall_nxt = 0; c_in_valid = 0; c_in_data = '0;
    c_out_ready = 0;
    h_flush = 0; h_stall_cur = 0; h_stall_nxt = 0; h_in_valid = 0; h_in_data = '0;
    h_out_ready = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("c_rst_vld", 32'(c_out_valid), 32'd0);
    check("c_rst_data", 32'(c_out_data), 32'(NOP));
    check("c_rst_occ", 32'(c_occ), 32'd0);
    check("c_rst_rdy", 32'(c_in_ready), 32'd1);
    check("h_rst_rdy", 32'(h_in_ready), 32'd1);
    check("h_rst_occ", 32'(h_occ), 32'd0);
    mon_en = 1;

    // Controller mode: load, hold, bubble, flush.
    c_in_valid = 1; c_in_data = 16'hA5A5;
    tick();
    check("c_load_vld", 32'(c_out_valid), 32'd1);
    check("c_load_data", 32'(c_out_data), 32'hA5A5);
    check("c_load_occ", 32'(c_occ), 32'd1);
    c_in_data = 16'h1111; c_stall_cur = 1; c_stall_nxt = 1;
    #1;
    check("c_stall_rdy", 32'(c_in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c_hold_data", 32'(c_out_data), 32'hA5A5);
      check("c_hold_vld", 32'(c_out_valid), 32'd1);
    end
    c_stall_nxt = 0;
    tick();
    check("c_bub_vld", 32'(c_out_valid), 32'd0);
    check("c_bub_data", 32'(c_out_data), 32'(NOP));
    check("c_bub_occ", 32'(c_occ), 32'd0);
    c_stall_cur = 0; c_in_valid = 0;
    tick();
    check("c_inv_data", 32'(c_out_data), 32'(NOP));
    c_in_valid = 1; c_in_data = 16'h2222;
    tick();
    check("c_ld2_data", 32'(c_out_data), 32'h2222);
    c_in_data = 16'h1234; c_flush = 1;
    tick();
    c_flush = 0; c_in_valid = 0;
    check("c_flush_vld", 32'(c_out_valid), 32'd0);
    check("c_flush_data", 32'(c_out_data), 32'(NOP));

    // Handshake: fill to FULL with downstream stalled.
    h_out_ready = 0; h_in_valid = 1; h_in_data = 16'd1;
    tick();
    check("h_p1_occ", 32'(h_occ), 32'd1);
    check("h_p1_rdy", 32'(h_in_ready), 32'd1);
    h_in_data = 16'd2;
    tick();
    check("h_p2_occ", 32'(h_occ), 32'd2);
    check("h_p2_rdy", 32'(h_in_ready), 32'd0);
    h_in_data = 16'd3;
    tick();
    check("h_p3_occ", 32'(h_occ), 32'd2);
    check("h_p3_data", 32'(h_out_data), 32'd1);

    // Drain two entries.
    h_in_valid = 0; h_out_ready = 1;
    tick();
    check("h_d1_data", 32'(h_out_data), 32'd2);
    check("h_d1_occ", 32'(h_occ), 32'd1);
    check("h_d1_rdy", 32'(h_in_ready), 32'd1);
    tick();
    check("h_d2_occ", 32'(h_occ), 32'd0);
    check("h_d2_vld", 32'(h_out_valid), 32'd0);
    check("h_d2_data", 32'(h_out_data), 32'(NOP));

    // Streaming at full throughput.
    for (int i = 0; i < 16; i++) begin
      h_in_valid = 1; h_in_data = DW'(i);
      tick();
      check("h_st_occ", 32'(h_occ), 32'd1);
      check("h_st_data", 32'(h_out_data), 32'(i));
    end
    h_in_valid = 0;
    tick();
    check("h_st_end", 32'(h_occ), 32'd0);

    // Flush in FULL with a simultaneous input.
    h_out_ready = 0; h_in_valid = 1; h_in_data = 16'h10;
    tick();
    h_in_data = 16'h20;
    tick();
    check("h_f_full", 32'(h_occ), 32'd2);
    h_flush = 1; h_in_data = 16'h77;
    tick();
    h_flush = 0; h_in_valid = 0;
    check("h_f_occ", 32'(h_occ), 32'd0);
    check("h_f_vld", 32'(h_out_valid), 32'd0);
    check("h_f_data", 32'(h_out_data), 32'(NOP));

    // Flush in ONE while in_ready=1: the offered entry is still dropped.
    h_in_valid = 1; h_in_data = 16'h55;
    tick();
    h_flush = 1; h_in_data = 16'h77;
    tick();
    h_flush = 0; h_in_valid = 0; h_out_ready = 1;
    check("h_f1_occ", 32'(h_occ), 32'd0);
    check("h_f1_data", 32'(h_out_data), 32'(NOP));
    tick();

    // Reset held two cycles while FULL.
    h_out_ready = 0; h_in_valid = 1; h_in_data = 16'h31;
    tick();
    h_in_data = 16'h32;
    tick();
    check("h_r_full", 32'(h_occ), 32'd2);
    rst = 1; h_in_data = 16'h33;
    tick();
    tick();
    rst = 0; h_in_valid = 0;
    check("h_r_vld", 32'(h_out_valid), 32'd0);
    check("h_r_data", 32'(h_out_data), 32'(NOP));
    check("h_r_occ", 32'(h_occ), 32'd0);
    check("h_r_rdy", 32'(h_in_ready), 32'd1);

    // Random traffic with occasional flushes, checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      h_in_valid  = 1'($urandom_range(0, 1));
      h_out_ready = ($urandom_range(0, 3) != 0);
      h_flush     = ($urandom_range(0, 31) == 0);
      h_in_data   = DW'($urandom);
      tick();
    end
    h_flush = 0; h_in_valid = 0; h_out_ready = 1;
    tick();
    tick();
    tick();
    check("h_drain_occ", 32'(h_occ), 32'd0);
    mon_en = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
